// File: rtl/me_mv_sequencer.sv
// Frame sequencer behind the full-search ME core: per-macroblock req/ack, index-to-MV
// conversion by repeated subtraction, valid/ready result port. Option: ME_INTRA_FLAG_EN.
module me_mv_sequencer #(
   parameter int SAD_WIDTH = 16,
   parameter int CNT_WIDTH = 12,
   parameter int TB_LENGTH = 16,
   parameter int SW_LENGTH = 64,
   parameter int MB_WIDTH  = 10,
   parameter int MV_WIDTH  = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [MB_WIDTH-1:0]  num_mb,
   output logic                 busy,
   output logic                 done,
   output logic                 me_req,
   input  logic                 me_ack,
   input  logic [CNT_WIDTH-1:0] me_min_cnt,
   input  logic [SAD_WIDTH-1:0] me_min_sad,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [MB_WIDTH-1:0]  out_mb_idx,
   output logic [MV_WIDTH-1:0]  out_mv_x,
   output logic [MV_WIDTH-1:0]  out_mv_y,
   output logic [SAD_WIDTH-1:0] out_sad
`ifdef ME_INTRA_FLAG_EN
   ,
   input  logic [SAD_WIDTH-1:0] sad_thresh,
   output logic                 out_intra
`endif
);

   localparam int POS  = SW_LENGTH - TB_LENGTH + 1;
   localparam int HALF = (SW_LENGTH - TB_LENGTH) / 2;

   localparam logic [CNT_WIDTH-1:0] POS_C    = CNT_WIDTH'(POS);
   localparam logic [CNT_WIDTH:0]   POS_SQ_C = (CNT_WIDTH + 1)'(POS * POS);
   localparam logic [CNT_WIDTH-1:0] HALF_C   = CNT_WIDTH'(HALF);
   localparam logic [MV_WIDTH:0]    HALF_Q   = (MV_WIDTH + 1)'(HALF);

   typedef enum logic [2:0] {IDLE, REQ, DIV, ACKFALL, EMIT} state_t;

   state_t                 state_q;
   logic                   busy_q, done_q, me_req_q, out_valid_q;
   logic [MB_WIDTH-1:0]    num_mb_q, mb_idx_q;
   logic [CNT_WIDTH-1:0]   rem_q;
   logic [MV_WIDTH:0]      q_q;
   logic [SAD_WIDTH-1:0]   sad_q;
   logic                   oor_q;
   logic [MB_WIDTH-1:0]    out_mb_idx_q;
   logic [MV_WIDTH-1:0]    out_mv_x_q, out_mv_y_q;
   logic [SAD_WIDTH-1:0]   out_sad_q;

   logic [MV_WIDTH-1:0]    mv_x_d, mv_y_d;
   logic                   last_mb_d;

   // Quotient is the outer (x) index, remainder the inner (y) index.
   assign mv_x_d    = oor_q ? '0 : MV_WIDTH'(q_q - HALF_Q);
   assign mv_y_d    = oor_q ? '0 : MV_WIDTH'(rem_q - HALF_C);
   assign last_mb_d = (mb_idx_q == num_mb_q - MB_WIDTH'(1));

`ifdef ME_INTRA_FLAG_EN
   logic out_intra_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_intra_q <= 1'b0;
      end else if (state_q == ACKFALL && !me_ack) begin
         out_intra_q <= (sad_q >= sad_thresh);
      end
   end
   assign out_intra = out_intra_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         me_req_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         num_mb_q     <= '0;
         mb_idx_q     <= '0;
         rem_q        <= '0;
         q_q          <= '0;
         sad_q        <= '0;
         oor_q        <= 1'b0;
         out_mb_idx_q <= '0;
         out_mv_x_q   <= '0;
         out_mv_y_q   <= '0;
         out_sad_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (num_mb == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     num_mb_q <= num_mb;
                     mb_idx_q <= '0;
                     busy_q   <= 1'b1;
                     me_req_q <= !me_ack;
                     state_q  <= REQ;
                  end
               end
            end
            REQ: begin
               // A request is only raised once the core has released ack.
               if (me_req_q && me_ack) begin
                  rem_q    <= me_min_cnt;
                  sad_q    <= me_min_sad;
                  oor_q    <= ({1'b0, me_min_cnt} >= POS_SQ_C);
                  q_q      <= '0;
                  me_req_q <= 1'b0;
                  state_q  <= DIV;
               end else if (!me_req_q && !me_ack) begin
                  me_req_q <= 1'b1;
               end
            end
            DIV: begin
               if (rem_q >= POS_C) begin
                  rem_q <= rem_q - POS_C;
                  q_q   <= q_q + 1'b1;
               end else begin
                  state_q <= ACKFALL;
               end
            end
            ACKFALL: begin
               if (!me_ack) begin
                  out_mb_idx_q <= mb_idx_q;
                  out_mv_x_q   <= mv_x_d;
                  out_mv_y_q   <= mv_y_d;
                  out_sad_q    <= sad_q;
                  out_valid_q  <= 1'b1;
                  state_q      <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (last_mb_d) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     mb_idx_q <= mb_idx_q + MB_WIDTH'(1);
                     me_req_q <= !me_ack;
                     state_q  <= REQ;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign me_req     = me_req_q;
   assign out_valid  = out_valid_q;
   assign out_mb_idx = out_mb_idx_q;
   assign out_mv_x   = out_mv_x_q;
   assign out_mv_y   = out_mv_y_q;
   assign out_sad    = out_sad_q;

endmodule

// File: tb/tb_me_mv_sequencer.sv
// Scoreboard bench for me_mv_sequencer: a behavioural ME core answers requests, a
// monitor pops expected results on every accepted output and checks stall stability.
module tb_me_mv_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  num_mb;
   logic        busy, done, me_req, me_ack;
   logic [11:0] me_min_cnt;
   logic [15:0] me_min_sad;
   logic        out_valid, out_ready;
   logic [9:0]  out_mb_idx;
   logic [6:0]  out_mv_x, out_mv_y;
   logic [15:0] out_sad;

   typedef logic [39:0] exp_t;
   typedef struct {
      int cnt;
      int sad;
      int hold;
   } me_t;

   exp_t exp_q[$];
   me_t  me_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   me_mv_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_mb     (num_mb),
      .busy       (busy),
      .done       (done),
      .me_req     (me_req),
      .me_ack     (me_ack),
      .me_min_cnt (me_min_cnt),
      .me_min_sad (me_min_sad),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mb_idx (out_mb_idx),
      .out_mv_x   (out_mv_x),
      .out_mv_y   (out_mv_y),
      .out_sad    (out_sad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, expv);
      end
   endtask

   task automatic push_mb(input int idx, input int cnt, input int sad, input int hold,
                          input int mx, input int my);
      me_t it;
      it.cnt  = cnt;
      it.sad  = sad;
      it.hold = hold;
      me_q.push_back(it);
      exp_q.push_back({10'(idx), 7'(mx), 7'(my), 16'(sad)});
   endtask

   task automatic start_frame(input int n);
      @(posedge clk); #1;
      start  = 1'b1;
      num_mb = 10'(n);
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 64'(seen), 64'd1);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("busy_after_done", 64'(busy), 64'd0);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Behavioural ME core: acks two cycles after a request, optionally holds ack afterwards.
   initial begin
      me_t it;
      me_ack     = 1'b0;
      me_min_cnt = '0;
      me_min_sad = '0;
      forever begin
         @(posedge clk); #2;
         if (rst_n && me_req && !me_ack && me_q.size() > 0) begin
            it = me_q.pop_front();
            repeat (2) @(posedge clk);
            #2;
            me_min_cnt = 12'(it.cnt);
            me_min_sad = 16'(it.sad);
            me_ack     = 1'b1;
            for (int i = 0; i < 100 && me_req; i++) begin
               @(posedge clk); #2;
            end
            check("req_dropped_on_ack", 64'(me_req), 64'd0);
            for (int i = 0; i < it.hold; i++) begin
               @(posedge clk); #2;
               check("req_low_while_ack", 64'(me_req), 64'd0);
               check("valid_low_while_ack", 64'(out_valid), 64'd0);
            end
            me_ack = 1'b0;
         end
      end
   end

   // Output monitor.
   initial begin
      logic prev_v, prev_r;
      exp_t prev_f, cur, e;
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_f = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_v = 1'b0;
         end else begin
            cur = {out_mb_idx, out_mv_x, out_mv_y, out_sad};
            if (prev_v && !prev_r) begin
               check("stall_valid_held", 64'(out_valid), 64'd1);
               check("stall_fields_held", 64'(cur), 64'(prev_f));
            end
            if (out_valid && !out_ready)
               check("stall_no_req", 64'(me_req), 64'd0);
            if (out_valid && out_ready) begin
               $display("out mb=%0d mv=(%0d,%0d) sad=%h", out_mb_idx,
                        $signed(out_mv_x), $signed(out_mv_y), out_sad);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_output: got mb=%0d required none", out_mb_idx);
               end else begin
                  e = exp_q.pop_front();
                  check("out_fields", 64'(cur), 64'(e));
               end
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_f = cur;
         end
      end
   end

   initial begin
      bit ok;
      rst_n     = 1'b0;
      start     = 1'b0;
      num_mb    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_me_req", 64'(me_req), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_fields", 64'({out_mb_idx, out_mv_x, out_mv_y, out_sad}), 64'd0);
      rst_n = 1'b1;

      // Single macroblock, centre of the window.
      push_mb(0, 1200, 16'h0123, 0, 0, 0);
      start_frame(1);
      wait_done(300);

      // Window corners and near-corner; MB1 holds ack 5 cycles; a start while busy is ignored.
      push_mb(0, 0,    16'h0010, 0, -24, -24);
      push_mb(1, 2400, 16'h0020, 5,  24,  24);
      push_mb(2, 50,   16'h0030, 0, -23, -23);
      start_frame(3);
      repeat (3) @(posedge clk);
      #1;
      check("busy_in_frame", 64'(busy), 64'd1);
      start  = 1'b1;
      num_mb = 10'd5;
      @(posedge clk); #1;
      start  = 1'b0;
      wait_done(600);

      // Consumer stall of 10 cycles on MB0; MB2 index is out of range.
      out_ready = 1'b0;
      push_mb(0, 98,   16'h0040, 0, -22, -24);
      push_mb(1, 300,  16'h0050, 0, -18, -18);
      push_mb(2, 2401, 16'hBEEF, 0,   0,   0);
      start_frame(3);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("stall_valid_seen", 64'(ok), 64'd1);
      repeat (10) @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_done(600);

      // Empty frame.
      start_frame(0);
      check("zero_busy", 64'(busy), 64'd0);
      check("zero_me_req", 64'(me_req), 64'd0);
      wait_done(4);
      check("zero_me_req_after", 64'(me_req), 64'd0);

      // Reset while MB2 is dividing.
      push_mb(0, 49,   16'h0060, 0, -23, -24);
      push_mb(1, 100,  16'h0070, 0, -22, -22);
      me_q.push_back('{2400, 16'h0080, 0});
      start_frame(4);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("reset_frame_two_out", 64'(ok), 64'd1);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (me_ack) begin
            ok = 1'b1;
            break;
         end
      end
      check("reset_frame_mb2_ack", 64'(ok), 64'd1);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_me_req", 64'(me_req), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      me_q.delete();
      exp_q.delete();

      // Fresh frame after reset restarts at mb_idx 0.
      push_mb(0, 1200, 16'h0007, 0, 0, 0);
      start_frame(1);
      wait_done(300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
